// File: rtl/fp_div_issue_buffer.sv
// fp_div_issue_buffer
// -------------------
// Sits in front of a fixed-latency, valid-only floating-point divider.
// Operand pairs are accepted on a ready/valid slave and forwarded to the
// divider in the same cycle. Each pair's tlast is remembered in a tag FIFO.
// When a quotient comes back, it is paired with the oldest tag and stored in
// a show-ahead result FIFO. That FIFO feeds a ready/valid master.
// A credit rule (in flight + buffered < DEPTH) means a result always has a
// free slot when it returns. A stalled downstream therefore never drops one.
//
// Handshake semantics: a transfer happens on a rising aclk edge where
// tvalid && tready are both high. Valid never depends on ready. The slave's
// s_tready comes only from registered state and does not depend on s_tvalid.
//
// Optional feature, macro FP_DIV_ZERO_FLAG_EN: each pair whose denominator
// is +/-0 gets a flag. The flag travels with the tag and appears on
// m_tuser_div0. Any such issue also sets the sticky err_div0.
//
// Ports:
//   aclk, aresetn          clock, asynchronous active-low reset
//   s_num_tdata/s_den_tdata/s_tlast/s_tvalid/s_tready   operand slave
//   div_a_*/div_b_*        operand outputs to the divider
//   div_result_tvalid/tdata  quotient from the divider
//   m_tdata/m_tlast/m_tvalid/m_tready   result master (show-ahead)
//   err_unexpected         sticky: divider result with nothing in flight
//   m_tuser_div0, err_div0 (FP_DIV_ZERO_FLAG_EN only)
module fp_div_issue_buffer #(
    parameter int DATA_W  = 32,
    parameter int LATENCY = 28,
    parameter int DEPTH   = 32
) (
    input  logic              aclk,
    input  logic              aresetn,
    input  logic [DATA_W-1:0] s_num_tdata,
    input  logic [DATA_W-1:0] s_den_tdata,
    input  logic              s_tlast,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic              div_a_tvalid,
    output logic [DATA_W-1:0] div_a_tdata,
    output logic              div_b_tvalid,
    output logic [DATA_W-1:0] div_b_tdata,
    input  logic              div_result_tvalid,
    input  logic [DATA_W-1:0] div_result_tdata,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tlast,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              err_unexpected
`ifdef FP_DIV_ZERO_FLAG_EN
    ,
    output logic              m_tuser_div0,
    output logic              err_div0
`endif
);

    localparam int CW = $clog2(DEPTH + 1);   // counters span 0..DEPTH
    localparam int PW = $clog2(DEPTH);       // FIFO index
`ifdef FP_DIV_ZERO_FLAG_EN
    localparam int TAG_W = 2;                // {div0, tlast}
`else
    localparam int TAG_W = 1;                // {tlast}
`endif

    // If the credit limit is smaller than the round trip, issue throttles
    // below one pair per cycle. Ordering and losslessness are unaffected.
    if (DEPTH < LATENCY + 1) begin : g_rate_limited
    end

    // Occupancy counters and FIFO pointers
    logic [CW-1:0] r_inflight;
    logic [CW-1:0] r_count;
    logic [PW-1:0] r_tag_wr;
    logic [PW-1:0] r_tag_rd;
    logic [PW-1:0] r_res_wr;
    logic [PW-1:0] r_res_rd;
    logic          r_err_unexpected;

    // Storage. No reset is needed: a slot is read only after it is written.
    logic [TAG_W-1:0]  r_tag_mem [DEPTH];
    logic [DATA_W-1:0] r_res_data[DEPTH];
    logic [TAG_W-1:0]  r_res_tag [DEPTH];

    logic             w_issue;
    logic             w_ret;
    logic             w_pop;
    logic             w_spurious;
    logic [TAG_W-1:0] w_tag_in;

    // DEPTH need not be a power of two, so the wrap compare is explicit.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign s_tready   = ({1'b0, r_inflight} + {1'b0, r_count}) < (CW + 1)'(DEPTH);
    assign w_issue    = s_tvalid && s_tready;
    assign w_ret      = div_result_tvalid && (r_inflight != '0);
    assign w_spurious = div_result_tvalid && (r_inflight == '0);
    assign w_pop      = m_tvalid && m_tready;

    assign div_a_tvalid = w_issue;
    assign div_b_tvalid = w_issue;
    assign div_a_tdata  = s_num_tdata;
    assign div_b_tdata  = s_den_tdata;

`ifdef FP_DIV_ZERO_FLAG_EN
    logic w_div0;
    logic r_err_div0;
    // The sign bit is ignored so that both +0 and -0 count as zero.
    assign w_div0       = (s_den_tdata[30:0] == 31'd0);
    assign w_tag_in     = {w_div0, s_tlast};
    assign m_tuser_div0 = r_res_tag[r_res_rd][1];
    assign err_div0     = r_err_div0;
`else
    assign w_tag_in = s_tlast;
`endif

    assign m_tvalid       = (r_count != '0);
    assign m_tdata        = r_res_data[r_res_rd];
    assign m_tlast        = r_res_tag[r_res_rd][0];
    assign err_unexpected = r_err_unexpected;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_inflight       <= '0;
            r_count          <= '0;
            r_tag_wr         <= '0;
            r_tag_rd         <= '0;
            r_res_wr         <= '0;
            r_res_rd         <= '0;
            r_err_unexpected <= 1'b0;
        end else begin
            if (w_issue) r_tag_wr <= ptr_next(r_tag_wr);
            if (w_ret) begin
                r_tag_rd <= ptr_next(r_tag_rd);
                r_res_wr <= ptr_next(r_res_wr);
            end
            if (w_pop) r_res_rd <= ptr_next(r_res_rd);

            // If issue and return happen together, the count stays the same.
            case ({w_issue, w_ret})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase

            case ({w_ret, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase

            // A result that no issue accounts for is dropped and flagged.
            if (w_spurious) r_err_unexpected <= 1'b1;
        end
    end

`ifdef FP_DIV_ZERO_FLAG_EN
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_err_div0 <= 1'b0;
        end else if (w_issue && w_div0) begin
            r_err_div0 <= 1'b1;
        end
    end
`endif

    // When inflight is between 1 and DEPTH-1, the tag write slot and read
    // slot are different. An issue and a return in the same cycle therefore
    // never touch the same tag entry.
    always_ff @(posedge aclk) begin
        if (w_issue) r_tag_mem[r_tag_wr] <= w_tag_in;
        if (w_ret) begin
            r_res_data[r_res_wr] <= div_result_tdata;
            r_res_tag[r_res_wr]  <= r_tag_mem[r_tag_rd];
        end
    end

endmodule

// File: tb/tb_fp_div_issue_buffer.sv
// Testbench for fp_div_issue_buffer.
// A behavioural divider stub returns each quotient LATENCY cycles after
// issue. The reference model is a queue of expected {div0, tlast, quotient}
// entries plus two occupancy numbers: outstanding and returned.
module tb_fp_div_issue_buffer;

    localparam int DATA_W  = 32;
    localparam int LATENCY = 28;
    localparam int DEPTH   = 32;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUT signals ----------------
    logic [DATA_W-1:0] s_num_tdata = '0;
    logic [DATA_W-1:0] s_den_tdata = '0;
    logic              s_tlast = 1'b0;
    logic              s_tvalid = 1'b0;
    logic              s_tready;
    logic              div_a_tvalid;
    logic [DATA_W-1:0] div_a_tdata;
    logic              div_b_tvalid;
    logic [DATA_W-1:0] div_b_tdata;
    logic              div_result_tvalid;
    logic [DATA_W-1:0] div_result_tdata;
    logic [DATA_W-1:0] m_tdata;
    logic              m_tlast;
    logic              m_tvalid;
    logic              m_tready = 1'b1;
    logic              err_unexpected;
`ifdef FP_DIV_ZERO_FLAG_EN
    logic              m_tuser_div0;
    logic              err_div0;
`endif

    fp_div_issue_buffer #(
        .DATA_W (DATA_W),
        .LATENCY(LATENCY),
        .DEPTH  (DEPTH)
    ) dut (
        .aclk             (clk),
        .aresetn          (rst_n),
        .s_num_tdata      (s_num_tdata),
        .s_den_tdata      (s_den_tdata),
        .s_tlast          (s_tlast),
        .s_tvalid         (s_tvalid),
        .s_tready         (s_tready),
        .div_a_tvalid     (div_a_tvalid),
        .div_a_tdata      (div_a_tdata),
        .div_b_tvalid     (div_b_tvalid),
        .div_b_tdata      (div_b_tdata),
        .div_result_tvalid(div_result_tvalid),
        .div_result_tdata (div_result_tdata),
        .m_tdata          (m_tdata),
        .m_tlast          (m_tlast),
        .m_tvalid         (m_tvalid),
        .m_tready         (m_tready),
        .err_unexpected   (err_unexpected)
`ifdef FP_DIV_ZERO_FLAG_EN
        ,
        .m_tuser_div0     (m_tuser_div0),
        .err_div0         (err_div0)
`endif
    );

    // ---------------- check bookkeeping ----------------
    int checks = 0;
    int errors = 0;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    // ---------------- divider stub ----------------
    function automatic logic [63:0] sp_to_dp(input logic [31:0] x);
        int e;
        e = int'(x[30:23]) - 127 + 1023;
        return {x[31], e[10:0], x[22:0], 29'd0};
    endfunction

    // IEEE single division for normal operands. Mantissa bits beyond the
    // single-precision width are truncated. Zero operands give signed inf or 0.
    function automatic logic [31:0] fp_div_model(input logic [31:0] a, input logic [31:0] b);
        real         q;
        logic [63:0] qb;
        int          e;
        if (b[30:0] == 31'd0) return {a[31] ^ b[31], 8'hFF, 23'd0};
        if (a[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
        q  = $bitstoreal(sp_to_dp(a)) / $bitstoreal(sp_to_dp(b));
        qb = $realtobits(q);
        e  = int'(qb[62:52]) - 1023 + 127;
        if (e >= 255) return {qb[63], 8'hFF, 23'd0};
        if (e <= 0) return {qb[63], 31'd0};
        return {qb[63], e[7:0], qb[51:29]};
    endfunction

    logic [DATA_W:0] stub_pipe[LATENCY];
    logic            spur_v = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) stub_pipe[i] <= '0;
        end else begin
            stub_pipe[0] <= {div_a_tvalid, fp_div_model(div_a_tdata, div_b_tdata)};
            for (int i = 1; i < LATENCY; i++) stub_pipe[i] <= stub_pipe[i-1];
        end
    end

    assign div_result_tvalid = stub_pipe[LATENCY-1][DATA_W] | spur_v;
    assign div_result_tdata  = stub_pipe[LATENCY-1][DATA_W-1:0];

    // ---------------- scoreboard / model ----------------
    logic [DATA_W+1:0] exp_q[$];   // {div0, tlast, quotient}, oldest first
    int m_out = 0;                 // accepted and not yet consumed downstream
    int m_res = 0;                 // returned from divider, not yet consumed
    bit exp_err = 1'b0;
    bit exp_err_div0 = 1'b0;
    int dut_pops = 0;

    always @(negedge clk) begin
        bit                exp_rdy;
        bit                exp_issue;
        bit                exp_ret;
        bit                exp_pop;
        logic [DATA_W+1:0] head;
        if (!rst_n) begin
            exp_q.delete();
            m_out = 0;
            m_res = 0;
            exp_err = 1'b0;
            exp_err_div0 = 1'b0;
            check("rst_m_tvalid", m_tvalid, 0);
            check("rst_err_unexpected", err_unexpected, 0);
        end else begin
            exp_rdy   = (m_out < DEPTH);
            exp_issue = s_tvalid && exp_rdy;
            check("s_tready", s_tready, exp_rdy);
            check("div_a_tvalid", div_a_tvalid, exp_issue);
            check("div_b_tvalid", div_b_tvalid, exp_issue);
            if (exp_issue) begin
                check("div_a_tdata", div_a_tdata, s_num_tdata);
                check("div_b_tdata", div_b_tdata, s_den_tdata);
            end
            check("m_tvalid", m_tvalid, m_res != 0);
            if (m_res != 0) begin
                head = exp_q[0];
                check("m_tdata", m_tdata, head[DATA_W-1:0]);
                check("m_tlast", m_tlast, head[DATA_W]);
`ifdef FP_DIV_ZERO_FLAG_EN
                check("m_tuser_div0", m_tuser_div0, head[DATA_W+1]);
`endif
            end
            check("err_unexpected", err_unexpected, exp_err);
`ifdef FP_DIV_ZERO_FLAG_EN
            check("err_div0", err_div0, exp_err_div0);
`endif
            if (m_tvalid && m_tready) dut_pops++;

            // Update the model with what happens at the coming rising edge.
            exp_ret = div_result_tvalid && (m_out - m_res > 0);
            if (div_result_tvalid && !(m_out - m_res > 0)) exp_err = 1'b1;
            exp_pop = (m_res != 0) && m_tready;
            if (exp_issue) begin
                exp_q.push_back({s_den_tdata[30:0] == 31'd0, s_tlast,
                                 fp_div_model(s_num_tdata, s_den_tdata)});
                m_out++;
                if (s_den_tdata[30:0] == 31'd0) exp_err_div0 = 1'b1;
            end
            if (exp_ret) m_res++;
            if (exp_pop) begin
                void'(exp_q.pop_front());
                m_res--;
                m_out--;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pair_num(input int k);
        logic [31:0] v;
        v = 32'h40000000 | ((k * 32'h1234) & 32'h007FFFFF);
        v[31] = k[2];
        return v;
    endfunction

    function automatic logic [31:0] pair_den(input int k);
        return 32'h3F800000 | ((k * 32'h777) & 32'h007FFFFF);
    endfunction

    // Hold one pair until it is accepted. The handshake takes place at the
    // edge that ends this task.
    task automatic send_pair(input logic [31:0] n, input logic [31:0] d, input logic l,
                             output int stalls);
        stalls = 0;
        s_tvalid = 1'b1;
        s_num_tdata = n;
        s_den_tdata = d;
        s_tlast = l;
        while (!s_tready && stalls < 2000) begin
            step();
            stalls++;
        end
        check("send_accept", s_tready, 1);
        step();
        s_tvalid = 1'b0;
    endtask

    int next_idx = 0;

    // Offer the pair sequence next_idx..upto-1 with s_tvalid held high.
    task automatic offer(input int upto, input int cycles);
        for (int c = 0; c < cycles && next_idx < upto; c++) begin
            s_tvalid = 1'b1;
            s_num_tdata = pair_num(next_idx);
            s_den_tdata = pair_den(next_idx);
            s_tlast = next_idx[0];
            if (s_tready) next_idx++;
            step();
        end
        s_tvalid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        m_tready = 1'b1;
        while (exp_q.size() != 0 && n < 1000) begin
            step();
            n++;
        end
        check({name, "_drained"}, m_tvalid, 0);
    endtask

    task automatic single_op(input logic [31:0] n, input logic [31:0] d, input logic l,
                             input logic [31:0] exp_d, input string name);
        int waitc = 0;
        int st;
        m_tready = 1'b1;
        send_pair(n, d, l, st);
        while (!m_tvalid && waitc < 200) begin
            step();
            waitc++;
        end
        // Pair accepted in cycle t; now in cycle t+1; result visible in t+LATENCY+1.
        check({name, "_latency"}, waitc, LATENCY);
        check({name, "_data"}, m_tdata, exp_d);
        check({name, "_last"}, m_tlast, l);
        step();
        check({name, "_one_cycle"}, m_tvalid, 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    initial begin
        int st;
        int total_stalls;
        int pops0;

        // Reset, then release it away from a clock edge.
        repeat (3) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("reset_s_tready", s_tready, 1);
        check("reset_m_tvalid", m_tvalid, 0);
        check("reset_err", err_unexpected, 0);
        step();

        // Single operations: 6.0/2.0 = 3.0 and 1.0/4.0 = 0.25.
        single_op(32'h40C00000, 32'h40000000, 1'b1, 32'h40400000, "single_6_2");
        single_op(32'h3F800000, 32'h40800000, 1'b0, 32'h3E800000, "single_1_4");

        // Stream 100 pairs back to back with the downstream always ready.
        total_stalls = 0;
        pops0 = dut_pops;
        for (int i = 0; i < 100; i++) begin
            send_pair(pair_num(i), pair_den(i), (i % 3) == 2, st);
            total_stalls += st;
        end
        check("stream_stalls", total_stalls, 0);
        drain("stream");
        check("stream_pops", dut_pops - pops0, 100);

        // Backpressure: only DEPTH pairs fit while the downstream is stalled.
        pops0 = dut_pops;
        next_idx = 0;
        m_tready = 1'b0;
        offer(40, 100);
        check("bp_accepted", next_idx, DEPTH);
        check("bp_s_tready_low", s_tready, 0);
        check("bp_m_tvalid_full", m_tvalid, 1);
        m_tready = 1'b1;
        offer(40, 300);
        check("bp_rest_accepted", next_idx, 40);
        drain("bp");
        check("bp_pops", dut_pops - pops0, 40);

        // Fill to full, then random downstream ready with continuous input.
        pops0 = dut_pops;
        next_idx = 0;
        m_tready = 1'b0;
        offer(1000, 40);
        for (int c = 0; c < 400; c++) begin
            m_tready = 1'($urandom_range(0, 1));
            s_tvalid = 1'b1;
            s_num_tdata = pair_num(next_idx);
            s_den_tdata = pair_den(next_idx);
            s_tlast = next_idx[0];
            if (s_tready) next_idx++;
            step();
        end
        s_tvalid = 1'b0;
        drain("rand");
        check("rand_pops", dut_pops - pops0, next_idx);

        // A result pulse with nothing in flight.
        repeat (LATENCY + 2) step();
        spur_v = 1'b1;
        step();
        spur_v = 1'b0;
        check("spur_err", err_unexpected, 1);
        repeat (3) step();
        check("spur_m_tvalid", m_tvalid, 0);

        // Reset with 10 operations in flight.
        for (int i = 0; i < 10; i++) send_pair(pair_num(i), pair_den(i), 1'b0, st);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_s_tready", s_tready, 1);
        check("midrst_m_tvalid", m_tvalid, 0);
        check("midrst_err", err_unexpected, 0);
        repeat (LATENCY + 5) step();
        check("midrst_no_stale", m_tvalid, 0);

`ifdef FP_DIV_ZERO_FLAG_EN
        // Divide by -0, then a normal 1.0/1.0.
        single_op(32'h3F800000, 32'h80000000, 1'b1, 32'hFF800000, "div0");
        check("div0_err", err_div0, 1);
        send_pair(32'h3F800000, 32'h3F800000, 1'b0, st);
        st = 0;
        while (!m_tvalid && st < 200) begin
            step();
            st++;
        end
        check("div0_clear_flag", m_tuser_div0, 0);
        check("div0_clear_data", m_tdata, 32'h3F800000);
        step();
`endif

        // Normal operation after the mid-stream reset: 10.0/5.0 = 2.0.
        single_op(32'h41200000, 32'h40A00000, 1'b1, 32'h40000000, "post_rst");

        repeat (2) step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
